// File: rtl/sram_bridge_pkg.sv
// Shared types and width helpers for the picorv32-to-OpenRAM banked bridge.
package sram_bridge_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic int row_width(input int words_per_bank);
        return $clog2(words_per_bank);
    endfunction

    // A single bank still needs a 1-bit bank field so the ports stay legal.
    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/sram_bank_decode.sv
// Combinational byte-address to {in_range, bank, row} decode for the banked SRAM window.
module sram_bank_decode
    import sram_bridge_pkg::*;
#(
    parameter int          NUM_BANKS      = 4,
    parameter int          WORDS_PER_BANK = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
)(
    input  logic [31:0]                         addr,
    output logic                                in_range,
    output logic [bank_width(NUM_BANKS)-1:0]    bank,
    output logic [$clog2(WORDS_PER_BANK)-1:0]   row
);

    localparam int          ROW_W       = row_width(WORDS_PER_BANK);
    localparam int          BANK_W      = bank_width(NUM_BANKS);
    localparam logic [30:0] TOTAL_WORDS = 31'(NUM_BANKS * WORDS_PER_BANK);

    // Word index with a borrow bit on top: idx[30] set means addr < BASE_ADDR.
    logic [30:0] idx;
    logic        unused_byte_lanes;

    assign idx               = {1'b0, addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign unused_byte_lanes = ^addr[1:0];

    assign in_range = !idx[30] && (idx < TOTAL_WORDS);
    assign row      = idx[ROW_W-1:0];
    assign bank     = idx[ROW_W +: BANK_W];

endmodule

// File: rtl/sram_banked_bridge.sv
// picorv32 native bus to NUM_BANKS OpenRAM single-port macros with valid/ready handshake.
module sram_banked_bridge
    import sram_bridge_pkg::*;
#(
    parameter int          NUM_BANKS      = 4,
    parameter int          WORDS_PER_BANK = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          READ_LATENCY   = 1
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mem_valid,
    input  logic                              mem_instr,
    input  logic [31:0]                       mem_addr,
    input  logic [31:0]                       mem_wdata,
    input  logic [3:0]                        mem_wstrb,
    output logic [31:0]                       mem_rdata,
    output logic                              mem_ready,
    output logic                              mem_err,
    output logic [NUM_BANKS-1:0]              sram_csb,
    output logic                              sram_web,
    output logic [3:0]                        sram_wmask,
    output logic [$clog2(WORDS_PER_BANK)-1:0] sram_addr,
    output logic [31:0]                       sram_din,
    input  logic [32*NUM_BANKS-1:0]           sram_dout
);

    localparam int ROW_W  = row_width(WORDS_PER_BANK);
    localparam int BANK_W = bank_width(NUM_BANKS);

    state_t              state;
    logic [BANK_W-1:0]   bank_q;
    logic                is_write_q;
    logic                err_q;
    logic [1:0]          cnt;

    logic                dec_in_range;
    logic [BANK_W-1:0]   dec_bank;
    logic [ROW_W-1:0]    dec_row;
    logic                unused_instr;

    // Fetches and data reads share one path until fetch/data arbitration exists.
    assign unused_instr = mem_instr;

    sram_bank_decode #(
        .NUM_BANKS      (NUM_BANKS),
        .WORDS_PER_BANK (WORDS_PER_BANK),
        .BASE_ADDR      (BASE_ADDR)
    ) u_decode (
        .addr     (mem_addr),
        .in_range (dec_in_range),
        .bank     (dec_bank),
        .row      (dec_row)
    );

    // NOTE: read data is muxed straight from the macro in RESP; registering it would cost a cycle.
    always_comb begin
        mem_rdata = '0;
        if (state == RESP && !is_write_q && !err_q)
            mem_rdata = sram_dout[{bank_q, 5'd0} +: 32];
    end

    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bank_q     <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
            sram_csb   <= '1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (dec_in_range) begin
                            bank_q     <= dec_bank;
                            is_write_q <= |mem_wstrb;
                            err_q      <= 1'b0;
                            sram_csb   <= ~(NUM_BANKS'(1) << dec_bank);
                            sram_web   <= ~|mem_wstrb;
                            sram_wmask <= mem_wstrb;
                            sram_addr  <= dec_row;
                            sram_din   <= mem_wdata;
                            state      <= ISSUE;
                        end else begin
                            is_write_q <= 1'b0;
                            err_q      <= 1'b1;
                            mem_ready  <= 1'b1;
                            mem_err    <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    // The macro has captured the access; release it so csb is low for one cycle only.
                    sram_csb <= '1;
                    sram_web <= 1'b1;
                    if (is_write_q || READ_LATENCY == 1) begin
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt   <= 2'(READ_LATENCY - 2);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_banked_bridge.sv
// Directed bench: two bridges (READ_LATENCY 1 and 3) each driving a behavioural OpenRAM bank model.
module tb_sram_banked_bridge;

    logic         clk;
    logic         rst       [2];
    logic         mem_valid [2];
    logic         mem_instr [2];
    logic [31:0]  mem_addr  [2];
    logic [31:0]  mem_wdata [2];
    logic [3:0]   mem_wstrb [2];
    logic [31:0]  mem_rdata [2];
    logic         mem_ready [2];
    logic         mem_err   [2];
    logic [3:0]   csb       [2];
    logic         web       [2];
    logic [3:0]   wmask     [2];
    logic [9:0]   sram_addr [2];
    logic [31:0]  din       [2];

    int checks = 0;
    int errors = 0;
    int bad_onehot = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : unit
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0]  mem  [4096];
        logic [31:0]  pipe [4][4];
        logic [127:0] dout;

        always @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (!csb[g][b]) begin
                    if (!web[g]) begin
                        for (int k = 0; k < 4; k++)
                            if (wmask[g][k]) mem[b*1024 + int'(sram_addr[g])][k*8 +: 8] <= din[g][k*8 +: 8];
                    end else begin
                        pipe[0][b] <= mem[b*1024 + int'(sram_addr[g])];
                    end
                end
                for (int s = 1; s < 4; s++) pipe[s][b] <= pipe[s-1][b];
            end
        end

        always_comb begin
            dout = '0;
            for (int b = 0; b < 4; b++) dout[32*b +: 32] = pipe[LAT-1][b];
        end

        always @(negedge clk)
            if (!rst[g] && !$onehot0(~csb[g])) bad_onehot <= bad_onehot + 1;

        sram_banked_bridge #(.READ_LATENCY(LAT)) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .mem_valid  (mem_valid[g]),
            .mem_instr  (mem_instr[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wstrb  (mem_wstrb[g]),
            .mem_rdata  (mem_rdata[g]),
            .mem_ready  (mem_ready[g]),
            .mem_err    (mem_err[g]),
            .sram_csb   (csb[g]),
            .sram_web   (web[g]),
            .sram_wmask (wmask[g]),
            .sram_addr  (sram_addr[g]),
            .sram_din   (din[g]),
            .sram_dout  (dout)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request; cyc is the cycle of mem_ready counted from the request cycle (99 = timeout).
    task automatic access(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                          output int cyc, output int low, output logic [3:0] csb_seen,
                          output logic [9:0] row_seen);
        @(posedge clk); #1;
        mem_valid[u] = 1'b1;
        mem_addr[u]  = addr;
        mem_wdata[u] = wdata;
        mem_wstrb[u] = wstrb;
        cyc = 0; low = 0; csb_seen = 4'hF; row_seen = '0; rdata = '0; err = 1'b0;
        while (1) begin
            @(negedge clk);
            if (csb[u] != 4'hF) begin
                low++;
                csb_seen = csb[u];
                row_seen = sram_addr[u];
            end
            if (mem_ready[u]) begin
                rdata = mem_rdata[u];
                err   = mem_err[u];
                break;
            end
            if (cyc == 20) begin
                cyc = 99;
                break;
            end
            cyc++;
        end
    endtask

    task automatic wr(input int u, input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] exp_csb, input logic [9:0] exp_row);
        logic [31:0] rd; logic e; int cyc; int low; logic [3:0] cs; logic [9:0] row;
        access(u, addr, data, strb, rd, e, cyc, low, cs, row);
        check({tag, "_cycles"}, cyc, 2);
        check({tag, "_csb"}, 32'(cs), 32'(exp_csb));
        check({tag, "_row"}, 32'(row), 32'(exp_row));
        check({tag, "_csb_len"}, low, 1);
        check({tag, "_err"}, 32'(e), 0);
    endtask

    task automatic rd_chk(input int u, input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_cyc, input int exp_low);
        logic [31:0] rd; logic e; int cyc; int low; logic [3:0] cs; logic [9:0] row;
        access(u, addr, 32'h0, 4'h0, rd, e, cyc, low, cs, row);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_rdata"}, rd, exp_data);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_csb_len"}, low, exp_low);
    endtask

    int bad;

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; mem_valid[u] = 1'b1; mem_instr[u] = 1'b0;
            mem_addr[u] = 32'h0000_1004; mem_wdata[u] = 32'h0; mem_wstrb[u] = 4'h0;
        end

        // Reset held with a pending request: nothing may be issued or completed.
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (csb[0] != 4'hF || mem_ready[0] || csb[1] != 4'hF || mem_ready[1]) bad++;
        end
        check("reset_quiet", bad, 0);
        check("reset_web", 32'(web[0]), 1);
        check("reset_wmask", 32'(wmask[0]), 0);
        check("reset_addr", 32'(sram_addr[0]), 0);
        check("reset_din", din[0], 0);
        check("reset_err", 32'(mem_err[0]), 0);
        check("reset_rdata", mem_rdata[0], 0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        mem_valid[0] = 1'b0; mem_valid[1] = 1'b0;

        // 0x1004 is word 0x401: bank 1, row 1.
        wr(0, "w_full", 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 4'b1101, 10'd1);
        rd_chk(0, "r_full", 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 2, 1);

        wr(0, "w_ones", 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 4'b1011, 10'd0);
        wr(0, "w_bytes", 32'h0000_2000, 32'h1122_3344, 4'b0101, 4'b1011, 10'd0);
        rd_chk(0, "r_bytes", 32'h0000_2000, 32'hFF22_FF44, 1'b0, 2, 1);

        rd_chk(0, "r_oor", 32'h0000_4000, 32'h0, 1'b1, 1, 0);
        rd_chk(0, "r_after_oor", 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 2, 1);
        mem_valid[0] = 1'b0;

        // Latency-3 unit: last word of the last bank, then back-to-back reads.
        wr(1, "l3_w_last", 32'h0000_3FFC, 32'hA5A5_0FFF, 4'hF, 4'b0111, 10'd1023);
        rd_chk(1, "l3_r_last", 32'h0000_3FFC, 32'hA5A5_0FFF, 1'b0, 4, 1);
        rd_chk(1, "l3_r_b2b", 32'h0000_3FFC, 32'hA5A5_0FFF, 1'b0, 4, 1);
        wr(1, "l3_w_low", 32'h0000_0008, 32'h1234_5678, 4'hF, 4'b1110, 10'd2);
        rd_chk(1, "l3_r_low", 32'h0000_0008, 32'h1234_5678, 1'b0, 4, 1);
        rd_chk(1, "l3_r_b2b2", 32'h0000_3FFC, 32'hA5A5_0FFF, 1'b0, 4, 1);

        // Reset while the latency-3 read sits in WAIT.
        @(posedge clk); #1;
        mem_valid[1] = 1'b1; mem_addr[1] = 32'h0000_0008; mem_wstrb[1] = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1; mem_valid[1] = 1'b0;
        bad = 0;
        @(negedge clk);
        if (mem_ready[1]) bad++;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready[1] || csb[1] != 4'hF || mem_rdata[1] != 32'h0) bad++;
        end
        check("rst_wait_quiet", bad, 0);
        rd_chk(1, "rst_wait_read", 32'h0000_0008, 32'h1234_5678, 1'b0, 4, 1);
        mem_valid[1] = 1'b0;

        repeat (2) @(negedge clk);
        check("csb_onehot", bad_onehot, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
